// File: rtl/parking_pkg.sv
// Shared types for the parking-lot occupancy path: gate sequence states and
// the {a,b} beam-sensor pair encoding.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E1   = 3'd1,
        E2   = 3'd2,
        E3   = 3'd3,
        X1   = 3'd4,
        X2   = 3'd5,
        X3   = 3'd6,
        BAD  = 3'd7
    } gate_state_t;

    // Bit 1 is the outer beam (a), bit 0 the inner beam (b); 1 = blocked.
    typedef logic [1:0] sens_t;

    localparam sens_t P_NONE = 2'b00;
    localparam sens_t P_A    = 2'b10;
    localparam sens_t P_AB   = 2'b11;
    localparam sens_t P_B    = 2'b01;

endpackage

// File: rtl/gate_decoder.sv
// One gate: two-flop synchronizer on the A/B beams followed by the passage
// sequence FSM, which emits a registered one-cycle enter or exit pulse.
module gate_decoder
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_sens,
    input  logic b_sens,
    output logic enter_evt,
    output logic exit_evt
);

    sens_t       sync_p0;
    sens_t       sync_p1;
    gate_state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= P_NONE;
            sync_p1   <= P_NONE;
            state     <= IDLE;
            enter_evt <= 1'b0;
            exit_evt  <= 1'b0;
        end else begin
            // sync_p0 may go metastable; only sync_p1 feeds the FSM
            sync_p0   <= {a_sens, b_sens};
            sync_p1   <= sync_p0;
            enter_evt <= 1'b0;
            exit_evt  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_p1 == P_A)      state <= E1;
                    else if (sync_p1 == P_B) state <= X1;
                end
                E1: case (sync_p1)
                    P_NONE: state <= IDLE;
                    P_A:    state <= E1;
                    P_AB:   state <= E2;
                    P_B:    state <= BAD;
                endcase
                E2: case (sync_p1)
                    P_NONE: state <= IDLE;
                    P_A:    state <= E1;
                    P_AB:   state <= E2;
                    P_B:    state <= E3;
                endcase
                E3: case (sync_p1)
                    P_NONE: begin
                        state     <= IDLE;
                        enter_evt <= 1'b1;
                    end
                    P_A:    state <= BAD;
                    P_AB:   state <= E2;
                    P_B:    state <= E3;
                endcase
                X1: case (sync_p1)
                    P_NONE: state <= IDLE;
                    P_A:    state <= BAD;
                    P_AB:   state <= X2;
                    P_B:    state <= X1;
                endcase
                X2: case (sync_p1)
                    P_NONE: state <= IDLE;
                    P_A:    state <= X3;
                    P_AB:   state <= X2;
                    P_B:    state <= X1;
                endcase
                X3: case (sync_p1)
                    P_NONE: begin
                        state    <= IDLE;
                        exit_evt <= 1'b1;
                    end
                    P_A:    state <= X3;
                    P_AB:   state <= X2;
                    P_B:    state <= BAD;
                endcase
                BAD: begin
                    if (sync_p1 == P_NONE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Lot occupancy controller: per-gate passage decoders merged into one
// saturating occupancy counter with full/empty/entry-allowed indicators.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] a_sens,
    input  logic [NUM_GATES-1:0] b_sens,
    output logic [NUM_GATES-1:0] enter_evt,
    output logic [NUM_GATES-1:0] exit_evt,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 full,
    output logic                 empty,
    output logic                 entry_allowed,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int SUM_W = CNT_W + 3;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    function automatic logic signed [SUM_W-1:0] popcount(input logic [NUM_GATES-1:0] v);
        logic signed [SUM_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            if (v[i]) cnt = cnt + SUM_W'(1);
        end
        return cnt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_occ(input logic signed [SUM_W-1:0] v);
        if (v > CAP_S)
            return CNT_W'(CAPACITY);
        else if (v < 0)
            return '0;
        else
            return v[CNT_W-1:0];
    endfunction

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_decoder u_gate (
            .clk       (clk),
            .reset     (reset),
            .a_sens    (a_sens[g]),
            .b_sens    (b_sens[g]),
            .enter_evt (enter_evt[g]),
            .exit_evt  (exit_evt[g])
        );
    end

    // Entries and exits of the same cycle net out before clamping
    logic signed [SUM_W-1:0] next_p0;

    always_comb begin
        next_p0 = signed'({3'b000, occupancy}) + popcount(enter_evt) - popcount(exit_evt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            occupancy <= sat_occ(next_p0);
            overflow  <= (next_p0 > CAP_S);
            underflow <= (next_p0 < 0);
        end
    end

    assign full          = (occupancy == CNT_W'(CAPACITY));
    assign empty         = (occupancy == '0);
    assign entry_allowed = !full;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl: directed passages plus randomized
// sensor traffic, checked against a path-walking passage model.
module tb_parking_lot_ctrl;

    localparam int NG  = 2;
    localparam int CAP = 16;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NG-1:0] a_sens, b_sens;
    logic [NG-1:0] enter_evt, exit_evt;
    logic [CW-1:0] occupancy;
    logic          full, empty, entry_allowed, overflow, underflow;

    parking_lot_ctrl #(.NUM_GATES(NG), .CAPACITY(CAP), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .a_sens        (a_sens),
        .b_sens        (b_sens),
        .enter_evt     (enter_evt),
        .exit_evt      (exit_evt),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .entry_allowed (entry_allowed),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    typedef struct { int due; logic [NG-1:0] en; logic [NG-1:0] ex; } evr_t;
    typedef struct { int due; int occ; bit ovf; bit unf; } cnr_t;
    evr_t evq[$];
    cnr_t cq[$];
    int   exp_occ = 0;

    // Passage model: a car walks a 3-step pattern path; 00 at the last step completes it.
    int m_dir[NG];   // 0 none, 1 entering, 2 exiting, 3 bad
    int m_pos[NG];
    int m_occ = 0;

    function automatic logic [1:0] path_pat(input int dir, input int pos);
        logic [1:0] ent[3];
        logic [1:0] ext[3];
        ent = '{2'b10, 2'b11, 2'b01};
        ext = '{2'b01, 2'b11, 2'b10};
        return (dir == 1) ? ent[pos] : ext[pos];
    endfunction

    function automatic int gate_step(input int g, input logic [1:0] p);
        int ev;
        ev = 0;
        if (m_dir[g] == 3) begin
            if (p == 2'b00) m_dir[g] = 0;
        end else if (m_dir[g] == 0) begin
            if (p == 2'b10) begin m_dir[g] = 1; m_pos[g] = 0; end
            else if (p == 2'b01) begin m_dir[g] = 2; m_pos[g] = 0; end
        end else if (p == 2'b00) begin
            if (m_pos[g] == 2) ev = m_dir[g];
            m_dir[g] = 0;
        end else if (p == path_pat(m_dir[g], m_pos[g])) begin
            ev = 0;
        end else if (m_pos[g] < 2 && p == path_pat(m_dir[g], m_pos[g] + 1)) begin
            m_pos[g]++;
        end else if (m_pos[g] > 0 && p == path_pat(m_dir[g], m_pos[g] - 1)) begin
            m_pos[g]--;
        end else begin
            m_dir[g] = 3;
        end
        return ev;
    endfunction

    function automatic logic [1:0] fwd_pat(input int g);
        if (m_dir[g] == 0) return ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
        if (m_dir[g] == 3 || m_pos[g] == 2) return 2'b00;
        return path_pat(m_dir[g], m_pos[g] + 1);
    endfunction

    task automatic model_cycle(input logic [1:0] p0, input logic [1:0] p1);
        logic [NG-1:0] en, ex;
        int ev, nxt;
        cnr_t c;
        en = '0;
        ex = '0;
        for (int g = 0; g < NG; g++) begin
            ev = gate_step(g, (g == 0) ? p0 : p1);
            if (ev == 1) en[g] = 1'b1;
            if (ev == 2) ex[g] = 1'b1;
        end
        if ((en | ex) != '0) begin
            evq.push_back('{cyc + 3, en, ex});
            nxt = m_occ + $countones(en) - $countones(ex);
            c.due = cyc + 4;
            c.ovf = (nxt > CAP);
            c.unf = (nxt < 0);
            m_occ = (nxt > CAP) ? CAP : (nxt < 0) ? 0 : nxt;
            c.occ = m_occ;
            cq.push_back(c);
        end
    endtask

    task automatic drive(input logic [1:0] p0, input logic [1:0] p1, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            a_sens = {p1[1], p0[1]};
            b_sens = {p1[0], p0[0]};
            model_cycle(p0, p1);
        end
    endtask

    task automatic entry_g0(); drive(2'b10,2'b00,1); drive(2'b11,2'b00,1); drive(2'b01,2'b00,1); drive(2'b00,2'b00,1); endtask
    task automatic exit_g0();  drive(2'b01,2'b00,1); drive(2'b11,2'b00,1); drive(2'b10,2'b00,1); drive(2'b00,2'b00,1); endtask
    task automatic entry_both(); drive(2'b10,2'b10,1); drive(2'b11,2'b11,1); drive(2'b01,2'b01,1); drive(2'b00,2'b00,1); endtask
    task automatic exit_both();  drive(2'b01,2'b01,1); drive(2'b11,2'b11,1); drive(2'b10,2'b10,1); drive(2'b00,2'b00,1); endtask
    task automatic idle(input int n); drive(2'b00, 2'b00, n); endtask

    // Monitor: pops the scoreboard whenever an expected or actual response is due.
    always @(negedge clk) begin
        evr_t r;
        cnr_t c;
        bit eo, eu;
        while (evq.size() > 0 && evq[0].due < cyc) begin
            r = evq.pop_front();
            check("evt_missing", 0, 1);
        end
        if (evq.size() > 0 && evq[0].due == cyc) begin
            r = evq.pop_front();
            check("enter_evt", int'(enter_evt), int'(r.en));
            check("exit_evt", int'(exit_evt), int'(r.ex));
        end else begin
            check("spurious_evt", int'({enter_evt, exit_evt}), 0);
        end
        eo = 1'b0;
        eu = 1'b0;
        while (cq.size() > 0 && cq[0].due < cyc) begin
            c = cq.pop_front();
            check("cnt_missing", 0, 1);
        end
        if (cq.size() > 0 && cq[0].due == cyc) begin
            c = cq.pop_front();
            exp_occ = c.occ;
            eo = c.ovf;
            eu = c.unf;
        end
        check("occupancy", int'(occupancy), exp_occ);
        check("overflow", int'(overflow), int'(eo));
        check("underflow", int'(underflow), int'(eu));
        check("full", int'(full), int'(exp_occ == CAP));
        check("empty", int'(empty), int'(exp_occ == 0));
        check("entry_allowed", int'(entry_allowed), int'(exp_occ != CAP));
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_occupancy"}, int'(occupancy), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_entry_allowed"}, int'(entry_allowed), 1);
        check({tag, "_pulses"}, int'({enter_evt, exit_evt, overflow, underflow}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] p0, p1;
        reset  = 1'b1;
        a_sens = '0;
        b_sens = '0;
        for (int g = 0; g < NG; g++) begin m_dir[g] = 0; m_pos[g] = 0; end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        #2;
        reset = 1'b0;

        // Entry on gate 0 with 3-cycle holds, then exit on gate 1
        drive(2'b00,2'b00,3); drive(2'b10,2'b00,3); drive(2'b11,2'b00,3);
        drive(2'b01,2'b00,3); drive(2'b00,2'b00,3);
        idle(6);
        drive(2'b00,2'b01,3); drive(2'b00,2'b11,3); drive(2'b00,2'b10,3); drive(2'b00,2'b00,3);
        idle(6);

        // Back-out and jump, then illegal sequences, then a legal entry
        drive(2'b10,2'b00,3); drive(2'b11,2'b00,3); drive(2'b10,2'b00,3); drive(2'b00,2'b00,3);
        drive(2'b10,2'b00,3); drive(2'b11,2'b00,3); drive(2'b00,2'b00,3);
        drive(2'b11,2'b00,3); drive(2'b01,2'b00,3); drive(2'b00,2'b00,3);
        drive(2'b10,2'b00,2); drive(2'b01,2'b00,2); drive(2'b11,2'b00,2); drive(2'b00,2'b00,2);
        entry_g0();
        idle(6);

        // Fill to capacity, overflow, then balanced entry/exit at full
        for (int i = 0; i < 7; i++) entry_both();
        entry_g0();
        idle(6);
        entry_g0();
        idle(6);
        entry_both();
        idle(6);
        drive(2'b10,2'b01,1); drive(2'b11,2'b11,1); drive(2'b01,2'b10,1); drive(2'b00,2'b00,1);
        idle(6);

        // Drain to empty, then underflow
        for (int i = 0; i < 8; i++) exit_both();
        idle(6);
        exit_g0();
        idle(6);
        exit_both();
        idle(6);

        // Asynchronous reset in the middle of an entry at E2
        entry_g0(); entry_g0();
        drive(2'b10,2'b00,2); drive(2'b11,2'b00,3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        evq.delete();
        cq.delete();
        m_occ = 0;
        exp_occ = 0;
        for (int g = 0; g < NG; g++) m_dir[g] = 0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #3;
        reset = 1'b0;
        drive(2'b01,2'b00,3); drive(2'b00,2'b00,3);
        idle(6);
        entry_g0();
        idle(6);

        // Randomized traffic, mostly forward progress with random disturbances
        for (int s = 0; s < 400; s++) begin
            p0 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : fwd_pat(0);
            p1 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : fwd_pat(1);
            drive(p0, p1, $urandom_range(1, 3));
        end
        idle(10);

        check("evq_drained", evq.size(), 0);
        check("cq_drained", cq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
